// File: rtl/stopwatch_laps.sv
// BCD stopwatch/countdown timer with synchronised start/lap buttons and a small
// lap memory. Two-process FSM: IDLE -> RUN <-> PAUSE, down mode ends in DONE.
module stopwatch_laps #(
   parameter int DIV       = 10,
   parameter int DIGITS    = 4,
   parameter int LAP_DEPTH = 4,
   localparam int LW       = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  pb_start,
   input  logic                  pb_lap,
   input  logic                  mode,
   input  logic [4*DIGITS-1:0]   preset,
   input  logic [LW-1:0]         lap_sel,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic [4*DIGITS-1:0]   lap_bcd,
   output logic [LW:0]           lap_count,
   output logic                  lap_full,
   output logic                  running,
   output logic                  time_done
);

   localparam int CW = 4 * DIGITS;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            mode_q, mode_d;
   logic [LW:0]     lap_count_q, lap_count_d;
   logic            start_meta_q, start_meta_d;
   logic            start_sync_q, start_sync_d;
   logic            start_dly_q, start_dly_d;
   logic            lap_meta_q, lap_meta_d;
   logic            lap_sync_q, lap_sync_d;
   logic            lap_dly_q, lap_dly_d;
   logic [CW-1:0]   lap_mem_q [2**LW];

   logic            start_pulse;
   logic            lap_pulse;
   logic            tick;
   logic            lap_full_w;
   logic            lap_we;
   logic [CW-1:0]   preset_clamped;
   logic [CW-1:0]   count_inc;
   logic [CW-1:0]   count_dec;

   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          carry;
      logic [3:0]    d;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (carry) begin
            if (d >= 4'd9) begin
               d     = 4'd0;
               carry = 1'b1;
            end else begin
               d     = d + 4'd1;
               carry = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      logic [3:0]    d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               d      = 4'd9;
               borrow = 1'b1;
            end else begin
               d      = d - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   always_comb begin
      preset_clamped = bcd_clamp(preset);
      count_inc      = bcd_inc(count_q);
      count_dec      = bcd_dec(count_q);
      tick           = (presc_q == PW'(DIV - 1));
      lap_full_w     = (lap_count_q == (LW+1)'(LAP_DEPTH));
      start_pulse    = start_sync_q & ~start_dly_q;
      lap_pulse      = lap_sync_q & ~lap_dly_q;
   end

   // Button path: meta -> sync -> delayed copy for rising-edge detection.
   always_comb begin
      start_meta_d = pb_start;
      start_sync_d = start_meta_q;
      start_dly_d  = start_sync_q;
      lap_meta_d   = pb_lap;
      lap_sync_d   = lap_meta_q;
      lap_dly_d    = lap_sync_q;
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      presc_d     = presc_q;
      mode_d      = mode_q;
      lap_count_d = lap_count_q;
      lap_we      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mode_d  = mode;
            count_d = mode ? preset_clamped : '0;
            presc_d = '0;
            if (start_pulse) begin
               if (mode && (preset_clamped == '0)) state_d = S_DONE;
               else                                state_d = S_RUN;
            end
         end
         S_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (start_pulse) begin
               state_d = S_PAUSE;
            end else if (lap_pulse && !lap_full_w) begin
               lap_we      = 1'b1;
               lap_count_d = lap_count_q + (LW+1)'(1);
            end
            // Reaching zero while counting down wins over a simultaneous stop.
            if (tick) begin
               if (!mode_q) begin
                  count_d = count_inc;
               end else if ((count_q == '0) || (count_dec == '0)) begin
                  count_d = '0;
                  state_d = S_DONE;
               end else begin
                  count_d = count_dec;
               end
            end
         end
         S_PAUSE: begin
            if (start_pulse) begin
               state_d = S_RUN;
            end else if (lap_pulse) begin
               state_d     = S_IDLE;
               count_d     = '0;
               lap_count_d = '0;
            end
         end
         S_DONE: begin
            count_d = '0;
            if (start_pulse || lap_pulse) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         presc_q      <= '0;
         mode_q       <= 1'b0;
         lap_count_q  <= '0;
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
         start_dly_q  <= 1'b0;
         lap_meta_q   <= 1'b0;
         lap_sync_q   <= 1'b0;
         lap_dly_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         presc_q      <= presc_d;
         mode_q       <= mode_d;
         lap_count_q  <= lap_count_d;
         start_meta_q <= start_meta_d;
         start_sync_q <= start_sync_d;
         start_dly_q  <= start_dly_d;
         lap_meta_q   <= lap_meta_d;
         lap_sync_q   <= lap_sync_d;
         lap_dly_q    <= lap_dly_d;
      end
   end

   // Lap storage needs no reset; reads are masked by lap_count instead.
   always_ff @(posedge clk) begin
      if (lap_we) lap_mem_q[lap_count_q[LW-1:0]] <= count_q;
   end

   always_comb begin
      lap_bcd = '0;
      if ({1'b0, lap_sel} < lap_count_q) lap_bcd = lap_mem_q[lap_sel];
   end

   assign count_bcd = count_q;
   assign lap_count = lap_count_q;
   assign lap_full  = lap_full_w;
   assign running   = (state_q == S_RUN);
   assign time_done = (state_q == S_DONE);

endmodule

// File: tb/tb_stopwatch_laps.sv
// Self-checking bench for stopwatch_laps: constant vectors, directed corner
// sequences and a randomized phase compared against a decimal-integer model.
module tb_stopwatch_laps;

   localparam int DIV       = 4;
   localparam int DIGITS    = 4;
   localparam int LAP_DEPTH = 2;
   localparam int LW        = 1;

   logic          clk;
   logic          nrst;
   logic          pb_start;
   logic          pb_lap;
   logic          mode;
   logic [15:0]   preset;
   logic [LW-1:0] lap_sel;
   logic [15:0]   count_bcd;
   logic [15:0]   lap_bcd;
   logic [LW:0]   lap_count;
   logic          lap_full;
   logic          running;
   logic          time_done;

   int n_checks;
   int n_fails;

   stopwatch_laps #(.DIV(DIV), .DIGITS(DIGITS), .LAP_DEPTH(LAP_DEPTH)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .pb_start  (pb_start),
      .pb_lap    (pb_lap),
      .mode      (mode),
      .preset    (preset),
      .lap_sel   (lap_sel),
      .count_bcd (count_bcd),
      .lap_bcd   (lap_bcd),
      .lap_count (lap_count),
      .lap_full  (lap_full),
      .running   (running),
      .time_done (time_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      pb_start = 1'b0;
      pb_lap   = 1'b0;
      nrst     = 1'b0;
      wait_n(2);
      nrst = 1'b1;
      wait_n(1);
   endtask

   // Returns on the negedge right after the edge that acts on the press.
   task automatic start_press();
      pb_start = 1'b1;
      wait_n(2);
      pb_start = 1'b0;
      wait_n(1);
   endtask

   task automatic lap_press();
      pb_lap = 1'b1;
      wait_n(2);
      pb_lap = 1'b0;
   endtask

   // Reference model: count kept as a plain decimal integer, buttons as sample history.
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
   mstate_t m_state;
   int      m_count;
   int      m_presc;
   int      m_lap_n;
   int      m_laps [LAP_DEPTH];
   bit      m_mode;
   bit [2:0] m_hs;
   bit [2:0] m_hl;

   function automatic int clamp_to_int(input logic [15:0] p);
      int r, w, d;
      r = 0;
      w = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(p[4*i +: 4]);
         if (d > 9) d = 9;
         r = r + d * w;
         w = w * 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] int_to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   always @(posedge clk or negedge nrst) begin
      bit      sp, lp, tk;
      int      pre, load;
      mstate_t nxt;
      if (!nrst) begin
         m_state = M_IDLE;
         m_count = 0;
         m_presc = 0;
         m_lap_n = 0;
         m_mode  = 1'b0;
         m_hs    = '0;
         m_hl    = '0;
      end else begin
         sp   = m_hs[1] & ~m_hs[2];
         lp   = m_hl[1] & ~m_hl[2];
         m_hs = {m_hs[1:0], pb_start};
         m_hl = {m_hl[1:0], pb_lap};
         nxt  = m_state;
         case (m_state)
            M_IDLE: begin
               m_mode  = mode;
               load    = mode ? clamp_to_int(preset) : 0;
               m_count = load;
               if (sp) begin
                  m_presc = 0;
                  nxt = (mode && load == 0) ? M_DONE : M_RUN;
               end
            end
            M_RUN: begin
               pre     = m_count;
               tk      = (m_presc == DIV - 1);
               m_presc = (m_presc + 1) % DIV;
               if (sp) nxt = M_PAUSE;
               else if (lp && m_lap_n < LAP_DEPTH) begin
                  m_laps[m_lap_n] = pre;
                  m_lap_n++;
               end
               if (tk) begin
                  if (!m_mode) m_count = (m_count + 1) % 10000;
                  else if (m_count <= 1) begin
                     m_count = 0;
                     nxt = M_DONE;
                  end else m_count = m_count - 1;
               end
            end
            M_PAUSE: begin
               if (sp) nxt = M_RUN;
               else if (lp) begin
                  nxt     = M_IDLE;
                  m_count = 0;
                  m_lap_n = 0;
               end
            end
            default: begin
               m_count = 0;
               if (sp || lp) nxt = M_IDLE;
            end
         endcase
         m_state = nxt;
      end
   end

   task automatic check_model();
      logic [15:0] exp_lap;
      exp_lap = (int'(lap_sel) < m_lap_n) ? int_to_bcd(m_laps[int'(lap_sel)]) : 16'h0000;
      check_eq("rnd_count", count_bcd, int_to_bcd(m_count));
      check_eq("rnd_running", running, (m_state == M_RUN));
      check_eq("rnd_done", time_done, (m_state == M_DONE));
      check_eq("rnd_lap_count", lap_count, m_lap_n);
      check_eq("rnd_lap_full", lap_full, (m_lap_n == LAP_DEPTH));
      check_eq("rnd_lap_bcd", lap_bcd, exp_lap);
   endtask

   typedef struct {
      logic        mode;
      logic [15:0] preset;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{mode: 1'b1, preset: 16'h0102, exp_count: 16'h0102};
      vecs[1] = '{mode: 1'b1, preset: 16'h00F0, exp_count: 16'h0090};
      vecs[2] = '{mode: 1'b1, preset: 16'hFFFF, exp_count: 16'h9999};
      vecs[3] = '{mode: 1'b1, preset: 16'hA5C3, exp_count: 16'h9593};
      vecs[4] = '{mode: 1'b0, preset: 16'h1234, exp_count: 16'h0000};
      vecs[5] = '{mode: 1'b1, preset: 16'h1234, exp_count: 16'h1234};

      n_checks = 0;
      n_fails  = 0;
      pb_start = 1'b0;
      pb_lap   = 1'b0;
      mode     = 1'b0;
      preset   = 16'h0000;
      lap_sel  = '0;
      nrst     = 1'b0;
      wait_n(3);

      check_eq("reset_count", count_bcd, 16'h0000);
      check_eq("reset_lap_count", lap_count, 0);
      check_eq("reset_lap_full", lap_full, 0);
      check_eq("reset_running", running, 0);
      check_eq("reset_done", time_done, 0);
      check_eq("reset_lap_bcd", lap_bcd, 16'h0000);
      nrst = 1'b1;
      wait_n(1);

      // IDLE preset loading and digit clamping.
      for (int i = 0; i < 6; i++) begin
         mode   = vecs[i].mode;
         preset = vecs[i].preset;
         wait_n(1);
         check_eq($sformatf("idle_load_%0d", i), count_bcd, vecs[i].exp_count);
         check_eq($sformatf("idle_stopped_%0d", i), running, 0);
      end

      // Up count, start latency and 9 -> 10 carry.
      mode   = 1'b0;
      preset = 16'h0000;
      wait_n(1);
      pb_start = 1'b1;
      wait_n(2);
      check_eq("start_latency_early", running, 0);
      pb_start = 1'b0;
      wait_n(1);
      check_eq("start_latency", running, 1);
      check_eq("up_start_count", count_bcd, 16'h0000);
      wait_n(39);
      check_eq("up_count_9", count_bcd, 16'h0009);
      wait_n(1);
      check_eq("up_count_10", count_bcd, 16'h0010);

      // Laps at 3, 7 and 9; the third is dropped because memory is full.
      do_reset();
      start_press();
      wait_n(10);
      lap_press();
      wait_n(14);
      lap_sel = 1'b1;
      #1;
      check_eq("lap_sel_unwritten", lap_bcd, 16'h0000);
      lap_sel = 1'b0;
      lap_press();
      wait_n(6);
      lap_press();
      wait_n(2);
      check_eq("laps_count", lap_count, 2);
      check_eq("laps_full", lap_full, 1);
      check_eq("laps_live", count_bcd, 16'h0009);
      lap_sel = 1'b0;
      #1;
      check_eq("lap0", lap_bcd, 16'h0003);
      lap_sel = 1'b1;
      #1;
      check_eq("lap1", lap_bcd, 16'h0007);
      lap_sel = 1'b0;

      // Pause freezes the count; lap in PAUSE clears back to IDLE.
      do_reset();
      start_press();
      wait_n(4);
      lap_press();
      wait_n(11);
      start_press();
      check_eq("pause_running", running, 0);
      check_eq("pause_count", count_bcd, 16'h0005);
      check_eq("pause_laps", lap_count, 1);
      wait_n(100);
      check_eq("pause_frozen", count_bcd, 16'h0005);
      #1;
      check_eq("pause_lap0", lap_bcd, 16'h0001);
      lap_press();
      wait_n(1);
      check_eq("clear_count", count_bcd, 16'h0000);
      check_eq("clear_laps", lap_count, 0);
      check_eq("clear_running", running, 0);

      // Countdown with borrow, mid-run mode change, DONE and reload.
      do_reset();
      mode   = 1'b1;
      preset = 16'h0102;
      wait_n(1);
      check_eq("timer_idle", count_bcd, 16'h0102);
      start_press();
      check_eq("timer_t0", count_bcd, 16'h0102);
      wait_n(4);
      check_eq("timer_t1", count_bcd, 16'h0101);
      wait_n(4);
      check_eq("timer_t2", count_bcd, 16'h0100);
      wait_n(4);
      check_eq("timer_borrow", count_bcd, 16'h0099);
      mode = 1'b0;
      wait_n(12);
      check_eq("timer_mode_ignored", count_bcd, 16'h0096);
      mode = 1'b1;
      wait_n(383);
      check_eq("timer_last", count_bcd, 16'h0001);
      check_eq("timer_last_run", running, 1);
      wait_n(1);
      check_eq("timer_zero", count_bcd, 16'h0000);
      check_eq("timer_done", time_done, 1);
      check_eq("timer_stopped", running, 0);
      wait_n(5);
      check_eq("done_holds", count_bcd, 16'h0000);
      start_press();
      check_eq("done_exit", time_done, 0);
      wait_n(1);
      check_eq("reload", count_bcd, 16'h0102);

      preset = 16'h0000;
      wait_n(1);
      start_press();
      check_eq("preset0_done", time_done, 1);
      check_eq("preset0_running", running, 0);
      lap_press();
      wait_n(1);
      check_eq("done_lap_exit", time_done, 0);

      // Start and lap together: start wins.
      do_reset();
      mode = 1'b0;
      start_press();
      wait_n(5);
      pb_start = 1'b1;
      pb_lap   = 1'b1;
      wait_n(2);
      pb_start = 1'b0;
      pb_lap   = 1'b0;
      wait_n(1);
      check_eq("both_running", running, 0);
      check_eq("both_laps", lap_count, 0);
      check_eq("both_count", count_bcd, 16'h0002);

      // A long hold produces exactly one start action.
      do_reset();
      pb_start = 1'b1;
      wait_n(50);
      pb_start = 1'b0;
      wait_n(20);
      check_eq("hold_running", running, 1);
      check_eq("hold_count", count_bcd, 16'h0016);

      // All-nines wraps to zero and keeps running.
      do_reset();
      start_press();
      wait_n(39999);
      check_eq("wrap_9999", count_bcd, 16'h9999);
      wait_n(1);
      check_eq("wrap_0000", count_bcd, 16'h0000);
      wait_n(4);
      check_eq("wrap_continue", count_bcd, 16'h0001);
      check_eq("wrap_running", running, 1);

      // Asynchronous reset in the middle of RUN.
      do_reset();
      start_press();
      wait_n(2);
      lap_press();
      wait_n(26);
      #2;
      nrst = 1'b0;
      #1;
      check_eq("async_running", running, 0);
      check_eq("async_count", count_bcd, 16'h0000);
      check_eq("async_laps", lap_count, 0);
      check_eq("async_full", lap_full, 0);
      check_eq("async_done", time_done, 0);
      check_eq("async_lap_bcd", lap_bcd, 16'h0000);
      @(negedge clk);
      nrst = 1'b1;
      wait_n(10);
      check_eq("post_reset_idle", running, 0);
      check_eq("post_reset_count", count_bcd, 16'h0000);

      // Randomized run against the reference model.
      do_reset();
      mode   = 1'b0;
      preset = 16'h0005;
      for (int c = 0; c < 3000; c++) begin
         check_model();
         if ($urandom_range(0, 9) == 0)  pb_start = ~pb_start;
         if ($urandom_range(0, 7) == 0)  pb_lap   = ~pb_lap;
         if ($urandom_range(0, 49) == 0) mode     = ~mode;
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
               0:       preset = 16'h0000;
               1:       preset = 16'h0003;
               2:       preset = {8'h00, 8'($urandom_range(0, 255))};
               default: preset = 16'($urandom_range(0, 65535));
            endcase
         end
         lap_sel = LW'($urandom_range(0, 1));
         nrst    = (c == 1500) ? 1'b0 : 1'b1;
         wait_n(1);
      end
      check_model();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/stopwatch_laps.md
STOPWATCH_LAPS -- requirements
Module: stopwatch_laps

Interface
REQ-001 SHALL have parameter DIV, default 10: clk cycles per count tick (>=2).
REQ-002 SHALL have parameter DIGITS, default 4: BCD digits in the count.
REQ-003 SHALL have parameter LAP_DEPTH, default 4: lap-memory entries (>=1). LW = max(1, clog2(LAP_DEPTH)).
REQ-004 SHALL have port clk, input, 1: system clock, rising edge.
REQ-005 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pb_start, input, 1: start/stop button, asynchronous level.
REQ-007 SHALL have port pb_lap, input, 1: lap/clear button, asynchronous level.
REQ-008 SHALL have port mode, input, 1: 0 = count up (stopwatch), 1 = count down (timer); sampled only in IDLE.
REQ-009 SHALL have port preset, input, 4*DIGITS: BCD start value for down mode.
REQ-010 SHALL have port lap_sel, input, LW: lap-memory read index.
REQ-011 SHALL have port count_bcd, output, 4*DIGITS: live count.
REQ-012 SHALL have port lap_bcd, output, 4*DIGITS: entry at lap_sel (combinational read), 0 if lap_sel >= lap_count.
REQ-013 SHALL have port lap_count, output, LW+1: stored laps.
REQ-014 SHALL have port lap_full, output, 1: lap_count == LAP_DEPTH.
REQ-015 SHALL have port running, output, 1: high in RUN.
REQ-016 SHALL have port time_done, output, 1: high in DONE.

Function
REQ-017 SHALL pass each button through a 2-flop synchroniser and a rising-edge detector: one single-cycle pulse per press, no further pulses while held.
REQ-018 SHALL take the state/count update on the 3rd rising clk edge after a button is first sampled high.
REQ-019 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-020 IDLE: count = 0 if mode=0, else preset with any digit >9 clamped to 9, reloaded every cycle; the mode value is latched every cycle; start pulse -> RUN.
REQ-021 RUN: prescaler counts 0..DIV-1; a tick occurs when it wraps; each tick BCD-increments (mode 0) or BCD-decrements (mode 1) count.
REQ-022 RUN: start pulse -> PAUSE; lap pulse -> write the current pre-tick count to entry lap_count and increment lap_count, ignored when lap_full.
REQ-023 PAUSE: count and prescaler hold; start pulse -> RUN, resuming the prescaler from its held value; lap pulse -> IDLE, with lap_count cleared to 0.
REQ-024 Down mode: a tick producing 0 -> DONE in the same edge, with count = 0; a tick is never applied at count 0.
REQ-025 Down mode: a preset of 0 with a start pulse -> DONE immediately.
REQ-026 DONE: count holds 0; start pulse or lap pulse -> IDLE, with laps retained.
REQ-027 Up mode: the all-nines count SHALL wrap to all-zero on the next tick and keep running, with no flag.
REQ-028 BCD arithmetic SHALL ripple carry/borrow per digit: 9+1 -> 0 with carry; 0-1 -> 9 with borrow.
REQ-029 Start and lap pulses in the same cycle: start wins, lap ignored.
REQ-030 Prescaler SHALL reset to 0 on every IDLE->RUN transition.
REQ-031 A mode change outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-032 nrst low SHALL immediately force IDLE, prescaler 0, count_bcd 0, lap_count 0, lap_full 0, running 0, time_done 0, and clear the synchroniser/edge flops.
REQ-033 Lap memory contents need not reset; lap_bcd SHALL be 0 after reset because lap_count = 0.
REQ-034 Reset asserted mid-RUN SHALL drop running asynchronously; after release, no button pulse SHALL occur unless a new rising edge is seen.

Verification (DIV=4, DIGITS=4, LAP_DEPTH=2)
REQ-035 Up count: mode=0, press start -> running=1 three edges later; after 40 cycles count_bcd=0x0010; 9->10 carry checked.
REQ-036 Laps: in RUN, three lap presses at counts 0x0003, 0x0007, 0x0009 -> lap_count=2, lap_full=1, lap_bcd(0)=0x0003, lap_bcd(1)=0x0007.
REQ-037 Pause/clear: start, 20 cycles, start -> count 0x0005 frozen for 100 cycles; lap -> IDLE, count 0, lap_count 0.
REQ-038 Timer: mode=1, preset=0x0102 -> after a start press, 0x0102, 0x0101, 0x0100, 0x0099 at 4-cycle ticks; reaches 0 -> time_done=1, running=0; start -> IDLE reloads 0x0102.
REQ-039 Edge cases: simultaneous start+lap in RUN -> PAUSE with lap_count unchanged; 0x9999 +1 tick -> 0x0000; preset 0x00F0 -> loads 0x0090; a button held 50 cycles -> exactly one action.
REQ-040 Async reset asserted mid-RUN with the count nonzero -> all outputs 0 before the next clk edge.
